// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register outstanding-write counters driving RAW and
// counter-saturation stalls for decode, cleared by write-back or flush.

module reg_cnt #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt
);
  logic nz;
  assign nz = (cnt != '0);

  // A decrement only takes effect on a non-zero count; an increment paired
  // with an effective decrement cancels out.
  always_ff @(posedge clk) begin
    if (rst || flush)                cnt <= '0;
    else if (inc && !(dec && nz))    cnt <= cnt + 1'b1;
    else if (!inc && dec && nz)      cnt <= cnt - 1'b1;
  end
endmodule

module reg_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int CW   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [AW-1:0]   issue_rs,
  input  logic [AW-1:0]   issue_rt,
  input  logic            issue_we,
  input  logic [AW-1:0]   issue_rd,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  output logic [NREG-1:0] busy_vec,
  output logic            err_underflow
);
  localparam logic [CW-1:0] CMAX = '1;

  logic [NREG-1:0][CW-1:0] cnt;
  logic                    raw, sat, accept, wr_inc, wb_dec, underflow;

  assign raw         = busy_vec[issue_rs] | busy_vec[issue_rt];
  assign sat         = issue_we & (issue_rd != '0) & (cnt[issue_rd] == CMAX);
  assign issue_ready = ~flush & ~raw & ~sat;
  assign accept      = issue_valid & issue_ready;
  assign wr_inc      = accept & issue_we & (issue_rd != '0);
  // Flush swallows the write-back, so it can never flag an underflow.
  assign wb_dec      = wb_valid & ~flush & (wb_rd != '0);
  assign underflow   = wb_dec & (cnt[wb_rd] == '0);

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    if (i == 0) begin : g_zero
      assign cnt[i] = '0;
    end else begin : g_lane
      reg_cnt #(.CW(CW)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .inc   (wr_inc & (issue_rd == AW'(i))),
        .dec   (wb_dec & (wb_rd == AW'(i))),
        .cnt   (cnt[i])
      );
    end
    assign busy_vec[i] = (cnt[i] != '0);
  end

  always_ff @(posedge clk) begin
    if (rst)            err_underflow <= 1'b0;
    else if (underflow) err_underflow <= 1'b1;
  end
endmodule
